plc_read_injector: RTL and testbench
====================================

PLC_READ_INJECTOR -- requirements
Module: plc_read_injector

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, cache index width; WAY_WIDTH, default 4, way-select width; DATA_SIZE, default 64, read data width; FIFO_DEPTH, default 4, power of 2, check-request queue depth; RD_LATENCY, default 2, range 1..7, cycles from read issue to valid rd_data.
REQ-002 Ports SHALL be (name  direction  width  meaning):
clk  in  1  single clock, rising edge;
rst_n  in  1  asynchronous, active-low reset;
req_valid  in  1  check request from PLC list;
req_addr  in  ADDR_WIDTH  line to check;
req_way  in  WAY_WIDTH  way to check;
req_ready  out  1  queue not full;
core_read_enable  in  1  native cache read this cycle;
core_write_enable  in  1  native cache write this cycle;
addr_out  out  ADDR_WIDTH  injected read address;
way_out  out  WAY_WIDTH  injected read way;
read_enable_out  out  1  injected read strobe;
alt_mx_sel_out  out  1  selects injected address at the cache read mux;
rd_data  in  DATA_SIZE  cache read data;
chk_valid  out  1  one-cycle pulse, check data ready;
chk_addr  out  ADDR_WIDTH  address of delivered data;
chk_way  out  WAY_WIDTH  way of delivered data;
chk_data  out  DATA_SIZE  captured rd_data;
overflow  out  1  sticky, request dropped;
collision_cnt  out  8  saturating count of aborted injections.

Function
REQ-003 The block SHALL push {req_addr, req_way} when req_valid=1 and req_ready=1; req_ready SHALL equal not-full.
REQ-004 req_valid=1 while full SHALL drop the request and set overflow, which stays set until reset.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT, DELIVER.
REQ-006 IDLE->ISSUE SHALL occur when the FIFO is non-empty and core_read_enable=0 and core_write_enable=0 in the same cycle; the FIFO head is registered into addr_out/way_out.
REQ-007 In ISSUE, read_enable_out and alt_mx_sel_out SHALL be 1 for exactly one cycle, unless core_read_enable=1 or core_write_enable=1 in that cycle, in which case both SHALL be 0 combinationally, the entry SHALL stay in the FIFO, collision_cnt SHALL increment (saturating at 255), and the next state SHALL be IDLE.
REQ-008 On an un-aborted ISSUE, the block SHALL pop the head and go to WAIT; WAIT SHALL last RD_LATENCY-1 cycles (0 cycles when RD_LATENCY=1).
REQ-009 rd_data SHALL be sampled on the clock edge RD_LATENCY cycles after the ISSUE edge into chk_data; the FSM then enters DELIVER.
REQ-010 DELIVER SHALL assert chk_valid for one cycle with chk_addr/chk_way equal to the issued address and way, then return to IDLE; total issue-to-chk_valid latency is RD_LATENCY+1 cycles.
REQ-011 chk_data/chk_addr/chk_way SHALL hold their values until the next DELIVER.
REQ-012 A push and a pop in the same cycle SHALL both take effect; a push SHALL be accepted even while full if a pop occurs in that cycle (req_ready stays not-full from the registered count; no bypass).
REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-014 At most one injected read SHALL be outstanding; there is no back-to-back issue.

Reset
REQ-015 rst_n=0 SHALL asynchronously clear the FIFO, set the FSM to IDLE, and zero all outputs including overflow and collision_cnt; req_ready SHALL be 1 after reset.
REQ-016 A reset asserted mid-injection SHALL discard the in-flight read; no chk_valid SHALL follow it.

Structure
REQ-017 ADDR_WIDTH/WAY_WIDTH/DATA_SIZE defaults and the FSM state encoding SHALL live in the shared plc_pkg package.
REQ-018 The queue SHALL be a sub-module plc_req_fifo (parameterised width/depth, push/pop/full/empty); the FSM and capture logic stay in plc_read_injector.

Verification
REQ-019 Scenario: reset, then push (0x12,0xC) with core idle -> read_enable_out=alt_mx_sel_out=1 with addr_out=0x12, way_out=0xC; rd_data=0x2 at RD_LATENCY -> chk_valid with chk_data=0x2, chk_addr=0x12, chk_way=0xC.
REQ-020 Scenario: push (0x55,0xF) while core_read_enable=1 for 5 cycles -> no injection until core idles, then exactly one injection of 0x55.
REQ-021 Scenario: core_read_enable rises in the ISSUE cycle -> outputs 0, collision_cnt=1, entry retried and later delivered.
REQ-022 Scenario: push 5 requests back-to-back with core busy (depth 4) -> 5th dropped, overflow=1, 4 deliveries in push order, with wrap exercised over two rounds.
REQ-023 Scenario: rst_n low during WAIT -> all outputs 0 immediately, no chk_valid afterwards, req_ready=1.

Source files
------------

// File: rtl/plc_pkg.sv
// Shared definitions for the PLC read-injection path: default widths,
// injector FSM encoding and a small saturating-counter helper.
package plc_pkg;

    localparam int PLC_ADDR_WIDTH = 8;
    localparam int PLC_WAY_WIDTH  = 4;
    localparam int PLC_DATA_SIZE  = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } inj_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/plc_req_fifo.sv
// Small request queue for check entries; head is visible combinationally,
// pointers wrap naturally because the depth is a power of two.
module plc_req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A pop frees the slot the simultaneous push lands in, so full does not block it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/plc_read_injector.sv
// Steals idle cache read slots to fetch queued {line, way} check requests
// and hands the returned data back with its address as a one-cycle pulse.
module plc_read_injector
    import plc_pkg::*;
#(
    parameter int ADDR_WIDTH = PLC_ADDR_WIDTH,
    parameter int WAY_WIDTH  = PLC_WAY_WIDTH,
    parameter int DATA_SIZE  = PLC_DATA_SIZE,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WAY_WIDTH-1:0]  req_way,
    output logic                  req_ready,
    input  logic                  core_read_enable,
    input  logic                  core_write_enable,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [WAY_WIDTH-1:0]  way_out,
    output logic                  read_enable_out,
    output logic                  alt_mx_sel_out,
    input  logic [DATA_SIZE-1:0]  rd_data,
    output logic                  chk_valid,
    output logic [ADDR_WIDTH-1:0] chk_addr,
    output logic [WAY_WIDTH-1:0]  chk_way,
    output logic [DATA_SIZE-1:0]  chk_data,
    output logic                  overflow,
    output logic [7:0]            collision_cnt
);

    localparam int ENTRY_W = ADDR_WIDTH + WAY_WIDTH;
    // WAIT is entered with this value and left once it reaches zero.
    localparam logic [2:0] WAIT_INIT = (RD_LATENCY >= 2) ? 3'(RD_LATENCY - 2) : 3'd0;

    inj_state_t            state_reg;
    inj_state_t            state_next;
    logic [2:0]            wait_cnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [WAY_WIDTH-1:0]  way_reg;
    logic                  chk_valid_reg;
    logic [ADDR_WIDTH-1:0] chk_addr_reg;
    logic [WAY_WIDTH-1:0]  chk_way_reg;
    logic [DATA_SIZE-1:0]  chk_data_reg;
    logic                  overflow_reg;
    logic [7:0]            collision_cnt_reg;

    logic                  core_busy;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  load_head;
    logic                  start_wait;
    logic                  capture;
    logic                  collide;
    logic                  issue_now;

    assign core_busy = core_read_enable || core_write_enable;

    plc_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .pop   (fifo_pop),
        .din   ({req_addr, req_way}),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        load_head  = 1'b0;
        issue_now  = 1'b0;
        fifo_pop   = 1'b0;
        start_wait = 1'b0;
        capture    = 1'b0;
        collide    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && !core_busy) begin
                    load_head  = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A native access in the issue cycle wins the port; retry from IDLE.
                if (core_busy) begin
                    collide    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    issue_now = 1'b1;
                    fifo_pop  = 1'b1;
                    if (RD_LATENCY == 1) begin
                        state_next = ST_DELIVER;
                    end else begin
                        start_wait = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 3'd0) begin
                    state_next = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                capture    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            wait_cnt_reg      <= 3'd0;
            addr_reg          <= '0;
            way_reg           <= '0;
            chk_valid_reg     <= 1'b0;
            chk_addr_reg      <= '0;
            chk_way_reg       <= '0;
            chk_data_reg      <= '0;
            overflow_reg      <= 1'b0;
            collision_cnt_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (load_head) begin
                {addr_reg, way_reg} <= head_entry;
            end
            if (start_wait) begin
                wait_cnt_reg <= WAIT_INIT;
            end else if (state_reg == ST_WAIT && wait_cnt_reg != 3'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 3'd1;
            end
            // rd_data is valid during DELIVER; the result appears the cycle after.
            chk_valid_reg <= capture;
            if (capture) begin
                chk_data_reg <= rd_data;
                chk_addr_reg <= addr_reg;
                chk_way_reg  <= way_reg;
            end
            if (collide) begin
                collision_cnt_reg <= sat_inc8(collision_cnt_reg);
            end
            if (req_valid && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign req_ready       = !fifo_full;
    assign addr_out        = addr_reg;
    assign way_out         = way_reg;
    assign read_enable_out = issue_now;
    assign alt_mx_sel_out  = issue_now;
    assign chk_valid       = chk_valid_reg;
    assign chk_addr        = chk_addr_reg;
    assign chk_way         = chk_way_reg;
    assign chk_data        = chk_data_reg;
    assign overflow        = overflow_reg;
    assign collision_cnt   = collision_cnt_reg;

endmodule

// File: tb/tb_plc_read_injector.sv
// Directed bench for plc_read_injector: a delayed-read cache model feeds
// rd_data, a negedge monitor logs issues and deliveries for checking.
module tb_plc_read_injector;

    localparam int RD_LAT = 2;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [3:0]  req_way = '0;
    logic        req_ready;
    logic        core_read_enable = 1'b0;
    logic        core_write_enable = 1'b0;
    logic [7:0]  addr_out;
    logic [3:0]  way_out;
    logic        read_enable_out;
    logic        alt_mx_sel_out;
    logic [63:0] rd_data;
    logic        chk_valid;
    logic [7:0]  chk_addr;
    logic [3:0]  chk_way;
    logic [63:0] chk_data;
    logic        overflow;
    logic [7:0]  collision_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0]  a;
        logic [3:0]  w;
        logic [63:0] d;
        logic        alt;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [7:0]  a;
        logic [3:0]  w;
        logic [63:0] exp_d;
    } vec_t;

    ev_t  issue_q[$];
    ev_t  deliv_q[$];
    vec_t vecs[5];
    logic [63:0] pipe [RD_LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    plc_read_injector #(
        .ADDR_WIDTH (8),
        .WAY_WIDTH  (4),
        .DATA_SIZE  (64),
        .FIFO_DEPTH (4),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_way           (req_way),
        .req_ready         (req_ready),
        .core_read_enable  (core_read_enable),
        .core_write_enable (core_write_enable),
        .addr_out          (addr_out),
        .way_out           (way_out),
        .read_enable_out   (read_enable_out),
        .alt_mx_sel_out    (alt_mx_sel_out),
        .rd_data           (rd_data),
        .chk_valid         (chk_valid),
        .chk_addr          (chk_addr),
        .chk_way           (chk_way),
        .chk_data          (chk_data),
        .overflow          (overflow),
        .collision_cnt     (collision_cnt)
    );

    function automatic logic [63:0] mem_word(input logic [7:0] a, input logic [3:0] w);
        if (a == 8'h12 && w == 4'hC) return 64'h2;
        return {8'hA5, 44'h0, a, w};
    endfunction

    // Cache model: data for a read strobed in cycle 0 is on rd_data in cycle RD_LAT only.
    always @(posedge clk) begin
        pipe[0] <= read_enable_out ? mem_word(addr_out, way_out) : JUNK;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RD_LAT-1];

    always @(negedge clk) begin
        if (read_enable_out) issue_q.push_back('{addr_out, way_out, 64'h0, alt_mx_sel_out, cyc});
        if (chk_valid) begin
            deliv_q.push_back('{chk_addr, chk_way, chk_data, 1'b0, cyc});
            $display("deliver #%0d cyc %0d: addr=%h way=%h data=%h",
                     deliv_q.size(), cyc, chk_addr, chk_way, chk_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [3:0] w);
        req_valid = 1'b1;
        req_addr  = a;
        req_way   = w;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_deliv(input int n, input int budget);
        for (int i = 0; i < budget && deliv_q.size() < n; i++) tick();
        check("deliv_count", 64'(deliv_q.size()), 64'(n));
    endtask

    task automatic wait_issue_negedge(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (read_enable_out) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_deliv(input int idx, input logic [7:0] a, input logic [3:0] w);
        if (idx < deliv_q.size()) begin
            check("order_addr", 64'(deliv_q[idx].a), 64'(a));
            check("order_way",  64'(deliv_q[idx].w), 64'(w));
            check("order_data", deliv_q[idx].d, mem_word(a, w));
        end else begin
            check("order_missing", 64'(deliv_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int  n_iss;
        int  n_dl;
        int  col0;
        bit  seen;

        vecs[0] = '{8'h12, 4'hC, 64'h0000_0000_0000_0002};
        vecs[1] = '{8'h00, 4'h0, 64'hA500_0000_0000_0000};
        vecs[2] = '{8'hFF, 4'hF, 64'hA500_0000_0000_0FFF};
        vecs[3] = '{8'h5A, 4'h3, 64'hA500_0000_0000_05A3};
        vecs[4] = '{8'hA5, 4'hA, 64'hA500_0000_0000_0A5A};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_read_en",   64'(read_enable_out), 64'd0);
        check("rst_alt_sel",   64'(alt_mx_sel_out), 64'd0);
        check("rst_chk_valid", 64'(chk_valid), 64'd0);
        check("rst_addr_out",  64'(addr_out), 64'd0);
        check("rst_chk_data",  chk_data, 64'd0);
        check("rst_overflow",  64'(overflow), 64'd0);
        check("rst_collision", 64'(collision_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Table: single requests with the core idle
        for (int i = 0; i < 5; i++) begin
            n_iss = issue_q.size();
            n_dl  = deliv_q.size();
            push(vecs[i].a, vecs[i].w);
            wait_deliv(n_dl + 1, 30);
            repeat (4) tick();
            check("vec_issue_cnt", 64'(issue_q.size()), 64'(n_iss + 1));
            check("vec_deliv_cnt", 64'(deliv_q.size()), 64'(n_dl + 1));
            if (issue_q.size() > n_iss && deliv_q.size() > n_dl) begin
                check("vec_issue_addr", 64'(issue_q[n_iss].a), 64'(vecs[i].a));
                check("vec_issue_way",  64'(issue_q[n_iss].w), 64'(vecs[i].w));
                check("vec_alt_sel",    64'(issue_q[n_iss].alt), 64'd1);
                check("vec_chk_addr",   64'(deliv_q[n_dl].a), 64'(vecs[i].a));
                check("vec_chk_way",    64'(deliv_q[n_dl].w), 64'(vecs[i].w));
                check("vec_chk_data",   deliv_q[n_dl].d, vecs[i].exp_d);
                check("vec_latency",    64'(deliv_q[n_dl].cyc - issue_q[n_iss].cyc), 64'(RD_LAT + 1));
            end
        end

        // Core busy for 5 cycles: injection must wait, then happen once
        n_iss = issue_q.size();
        n_dl  = deliv_q.size();
        core_read_enable = 1'b1;
        push(8'h55, 4'hF);
        repeat (4) tick();
        check("busy_no_issue", 64'(issue_q.size()), 64'(n_iss));
        core_read_enable = 1'b0;
        wait_deliv(n_dl + 1, 30);
        repeat (4) tick();
        check("busy_issue_cnt", 64'(issue_q.size()), 64'(n_iss + 1));
        check_deliv(n_dl, 8'h55, 4'hF);

        // Collision in the ISSUE cycle: aborted, counted, retried
        n_iss = issue_q.size();
        n_dl  = deliv_q.size();
        col0  = collision_cnt;
        push(8'h3C, 4'h6);
        tick();
        core_read_enable = 1'b1;
        @(negedge clk);
        check("col_read_en", 64'(read_enable_out), 64'd0);
        check("col_alt_sel", 64'(alt_mx_sel_out), 64'd0);
        @(posedge clk);
        #1;
        core_read_enable = 1'b0;
        @(negedge clk);
        check("col_count", 64'(collision_cnt), 64'(col0 + 1));
        check("col_no_issue", 64'(issue_q.size()), 64'(n_iss));
        wait_deliv(n_dl + 1, 30);
        check_deliv(n_dl, 8'h3C, 4'h6);

        // Full queue, push accepted in the cycle the head is popped
        tick();
        n_dl = deliv_q.size();
        core_write_enable = 1'b1;
        push(8'hB0, 4'h0);
        push(8'hB1, 4'h1);
        push(8'hB2, 4'h2);
        push(8'hB3, 4'h3);
        @(negedge clk);
        check("full_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        core_write_enable = 1'b0;
        wait_issue_negedge(10, seen);
        check("full_issue_seen", 64'(seen), 64'd1);
        req_valid = 1'b1;
        req_addr  = 8'hB4;
        req_way   = 4'h4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_deliv(n_dl + 5, 80);
        check("full_pop_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) check_deliv(n_dl + i, 8'hB0 + 8'(i), 4'(i));

        // Overflow: fifth push while busy is dropped
        tick();
        n_dl = deliv_q.size();
        core_read_enable = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 4'(8 + i));
        @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
        @(posedge clk);
        #1;
        core_read_enable = 1'b0;
        wait_deliv(n_dl + 4, 60);
        repeat (10) tick();
        check("ovf_deliv_cnt", 64'(deliv_q.size()), 64'(n_dl + 4));
        check("ovf_sticky", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) check_deliv(n_dl + i, 8'hC0 + 8'(i), 4'(8 + i));

        // Reset during WAIT discards the in-flight read
        n_dl = deliv_q.size();
        push(8'h77, 4'h7);
        wait_issue_negedge(10, seen);
        check("rstw_issue_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstw_read_en",   64'(read_enable_out), 64'd0);
        check("rstw_chk_valid", 64'(chk_valid), 64'd0);
        check("rstw_addr_out",  64'(addr_out), 64'd0);
        check("rstw_chk_data",  chk_data, 64'd0);
        check("rstw_overflow",  64'(overflow), 64'd0);
        check("rstw_collision", 64'(collision_cnt), 64'd0);
        check("rstw_req_ready", 64'(req_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rstw_no_deliv", 64'(deliv_q.size()), 64'(n_dl));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
